div_unit: RTL



---
 rtl/div_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
//-----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU
// instructions. It sits beside the execute-stage ALU and sees the same
// register operands the ALU receives, plus funct3. One quotient bit is
// produced per clock. The registered result is handed to the ALU result mux
// through a valid/ready handshake, and busy stalls the pipeline while an
// operation is in flight.
//
// Division by zero and signed overflow never iterate. They produce the
// RISC-V architected results one cycle after the operation is accepted.
//
// Parameters
//   XLEN   operand and result width
//   CNT_W  iteration counter width (2**CNT_W must exceed XLEN)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   i_start         launch request, sampled only while idle
//   i_funct3        4=DIV, 5=DIVU, 6=REM, 7=REMU (0..3 are ignored)
//   i_op_a          dividend (rs1)
//   i_op_b          divisor (rs2)
//   i_flush         abort the current operation; outranks everything else
//   o_busy          high while calculating or holding a result
//   o_result_valid  result is available
//   i_result_ready  consumer accepts the result
//   o_result        quotient or remainder, selected by the latched funct3
//-----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_result_valid,
    input  logic            i_result_ready,
    output logic [XLEN-1:0] o_result
);

    // Controller states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value on the edge that performs the final iteration
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    // Most negative signed value, the only dividend that can overflow
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic             r_want_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_result;

    // Operand decode at accept time
    logic             w_is_signed;
    logic             w_want_rem;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_overflow;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic [XLEN-1:0]  w_special_result;
    logic             w_accept;

    // Iteration datapath
    logic [XLEN:0]    w_rem_sh;
    logic             w_fits;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quo_next;
    logic [XLEN-1:0]  w_calc_result;

    //-------------------------------------------------------------------------
    // Operand decode.
    // Odd funct3 codes are the unsigned forms. Bit 1 selects the remainder.
    // Signed operands are reduced to magnitudes so that the core loop is
    // always unsigned. The signs are reapplied once at the end. The quotient
    // sign is suppressed for a zero divisor because that case bypasses the
    // loop anyway. Keeping neg_q consistent avoids surprises if the bypass is
    // ever removed.
    //-------------------------------------------------------------------------
    always_comb begin
        w_is_signed = ~i_funct3[0];
        w_want_rem  = i_funct3[1];
        w_a_neg     = w_is_signed & i_op_a[XLEN-1];
        w_b_neg     = w_is_signed & i_op_b[XLEN-1];
        w_abs_a     = w_a_neg ? (-i_op_a) : i_op_a;
        w_abs_b     = w_b_neg ? (-i_op_b) : i_op_b;
        w_b_zero    = (i_op_b == '0);
        w_overflow  = w_is_signed & (i_op_a == MIN_INT) & (i_op_b == '1);

        // Architected results for the two cases that skip the loop.
        // Division by zero: the quotient is all ones and the remainder is the
        // dividend.
        // Signed overflow: the quotient is MIN_INT and the remainder is zero.
        if (w_b_zero) begin
            w_special_result = w_want_rem ? i_op_a : '1;
        end else begin
            w_special_result = w_want_rem ? '0 : MIN_INT;
        end

        // Only the M-extension divide codes (funct3[2] set) launch anything,
        // and a simultaneous flush wins over start.
        w_accept = (r_state == S_IDLE) & i_start & ~i_flush & i_funct3[2];
    end

    //-------------------------------------------------------------------------
    // One restoring step.
    // {R,Q} shifts left by one, which pulls the next dividend bit into R.
    // The shifted remainder needs XLEN+1 bits because R can be as large as
    // divisor-1, and the divisor can be near 2**XLEN for unsigned operands.
    // When the trial subtraction fits, the true difference is below the
    // divisor. That means the low XLEN bits of the subtraction are exact.
    // The final result is formed from these next-state values so that it can
    // be registered on the same edge as the last iteration.
    //-------------------------------------------------------------------------
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[XLEN-1]};
        w_fits     = (w_rem_sh >= {1'b0, r_divisor});
        w_rem_next = w_fits ? (w_rem_sh[XLEN-1:0] - r_divisor) : w_rem_sh[XLEN-1:0];
        w_quo_next = {r_quo[XLEN-2:0], w_fits};

        if (r_want_rem) begin
            w_calc_result = r_neg_r ? (-w_rem_next) : w_rem_next;
        end else begin
            w_calc_result = r_neg_q ? (-w_quo_next) : w_quo_next;
        end
    end

    //-------------------------------------------------------------------------
    // Control FSM and datapath registers.
    // IDLE latches everything the operation needs on accept. After that the
    // input operands and funct3 may change freely. Special cases jump
    // straight to DONE with the result already registered.
    // CALC runs exactly XLEN iterations and registers the result on the edge
    // of the last one.
    // DONE holds the result until the consumer takes it.
    // Flush drops the operation from CALC or DONE without touching the
    // result register, so no result is ever delivered for it.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_divisor  <= w_abs_b;
                        r_want_rem <= w_want_rem;
                        r_neg_q    <= w_is_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]) & ~w_b_zero;
                        r_neg_r    <= w_a_neg;
                        if (w_b_zero || w_overflow) begin
                            r_result <= w_special_result;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_result <= w_calc_result;
                            r_state  <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (i_flush || i_result_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Outputs come straight from registered state. The consumer never sees a
    // combinational path from the divider inputs.
    //-------------------------------------------------------------------------
    always_comb begin
        o_busy         = (r_state != S_IDLE);
        o_result_valid = (r_state == S_DONE);
        o_result       = r_result;
    end

endmodule
